// File: rtl/io_bridge_pkg.sv
// Shared address map and read-source type for the cpu IO bridge.
// Imported by io_bridge and io_tx_fifo.
package io_bridge_pkg;

  localparam logic [17:0] IO_RXTX   = 18'h30000;
  localparam logic [17:0] IO_CLK    = 18'h30004;
  localparam logic [17:0] IO_STATUS = 18'h30008;

  typedef enum logic {
    SRC_RAM,
    SRC_IO
  } rd_src_t;

  function automatic logic [7:0] cnt_byte(
    input logic [31:0] v,
    input logic [1:0]  idx
  );
    logic [31:0] s;
    s = v >> {idx, 3'b000};
    return s[7:0];
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// UART TX byte FIFO: power-of-2 depth, pop on valid&ready.
// A push at full is accepted only when a pop frees a slot that cycle.
module io_tx_fifo
  import io_bridge_pkg::*;
#(
  parameter int TX_DEPTH = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        push_i,
  input  logic [7:0]                  data_i,
  input  logic                        ready_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  output logic                        full_o,
  output logic [$clog2(TX_DEPTH):0]   count_d_o
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [TX_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop;
  logic          push_ok;

  assign valid_o   = (cnt_q != '0);
  assign full_o    = (cnt_q == CW'(TX_DEPTH));
  assign pop       = valid_o & ready_i;
  assign push_ok   = push_i & (~full_o | pop);
  assign data_o    = mem_q[rd_q];
  assign count_d_o = cnt_d;

  always_comb begin
    wr_d  = wr_q + AW'(push_ok);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/io_bridge.sv
// cpu byte-bus bridge: RAM/MMIO decode, UART TX FIFO, RX, cycle counter, halt.
// IO_BRIDGE_STATUS_EN enables the 0x30008 status register read.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic        ram_r_nw,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        halt_out
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [17:0]   a18;
  logic          io_sel, rd_acc, wr_acc;
  logic          unused_hi;
  rd_src_t       src_q, src_d;
  logic [7:0]    io_rd_q, io_rd_d;
  logic [31:0]   cnt_q, snap_q, snap_d;
  logic          halt_q, halt_d;
  logic          ovf_q, ovf_d, ovf_set;
  logic          stat_clr;
  logic          full_q, halt_out_q;
  logic          push;
  logic [7:0]    push_data;
  logic          fifo_full;
  logic [CW-1:0] count_d;

  assign a18       = cpu_a[17:0];
  assign unused_hi = ^cpu_a[31:18];
  assign io_sel    = (a18[17:16] == 2'b11);
  assign rd_acc    = rdy_in & ~cpu_wr;
  assign wr_acc    = rdy_in & cpu_wr & io_sel;

  assign ram_r_nw = ~(cpu_wr & ~io_sel);
  assign ram_a    = cpu_a[16:0];
  assign ram_din  = cpu_dout;

  assign cpu_din        = (src_q == SRC_RAM) ? ram_dout : io_rd_q;
  assign io_buffer_full = full_q;
  assign halt_out       = halt_out_q;

  always_comb begin
    src_d     = SRC_IO;
    io_rd_d   = 8'h00;
    snap_d    = snap_q;
    rx_pop    = 1'b0;
    stat_clr  = 1'b0;
    push      = 1'b0;
    push_data = cpu_dout;
    halt_d    = halt_q;
    if (rd_acc & ~io_sel) src_d = SRC_RAM;
    if (rd_acc & io_sel) begin
      unique case (1'b1)
        a18 == IO_RXTX: begin
          io_rd_d = rx_valid ? rx_data : 8'h00;
          rx_pop  = rx_valid & ~rst_in;
        end
        a18 == IO_CLK: begin
          io_rd_d = cnt_q[7:0];
          snap_d  = cnt_q;
        end
        (a18[17:2] == IO_CLK[17:2]) &&
        (a18[1:0] != 2'b00):
          io_rd_d = cnt_byte(snap_q, a18[1:0]);
`ifdef IO_BRIDGE_STATUS_EN
        a18 == IO_STATUS: begin
          io_rd_d  = {ovf_q, halt_q, full_q,
                      tx_valid, 4'b0000};
          stat_clr = 1'b1;
        end
`endif
        default: ;
      endcase
    end
    if (wr_acc) begin
      unique case (1'b1)
        a18 == IO_RXTX:
          push = ~halt_q & (cpu_dout != 8'h00);
        // the stop marker must reach the UART, so skip the zero filter
        a18 == IO_CLK: begin
          halt_d    = 1'b1;
          push      = 1'b1;
          push_data = 8'h00;
        end
        default: ;
      endcase
    end
    ovf_set = push & fifo_full & ~(tx_valid & tx_ready);
    ovf_d   = ovf_set | (ovf_q & ~stat_clr);
  end

  io_tx_fifo #(
    .TX_DEPTH (TX_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_i    (push),
    .data_i    (push_data),
    .ready_i   (tx_ready),
    .data_o    (tx_data),
    .valid_o   (tx_valid),
    .full_o    (fifo_full),
    .count_d_o (count_d)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_q      <= SRC_IO;
      io_rd_q    <= 8'h00;
      snap_q     <= '0;
      cnt_q      <= '0;
      halt_q     <= 1'b0;
      ovf_q      <= 1'b0;
      full_q     <= 1'b0;
      halt_out_q <= 1'b0;
    end else begin
      src_q      <= src_d;
      io_rd_q    <= io_rd_d;
      snap_q     <= snap_d;
      cnt_q      <= rdy_in ? cnt_q + 32'd1 : cnt_q;
      halt_q     <= halt_d;
      ovf_q      <= ovf_d;
      full_q     <= (count_d >= CW'(TX_DEPTH - FULL_MARGIN));
      halt_out_q <= halt_q & ~tx_valid;
    end
  end

endmodule
